// File: rtl/bus_pkg.sv
// Shared helpers for the round-robin bus matrix: width math, arbiter state
// encoding and the "no slave selected" decode value.
package bus_pkg;

    localparam int DECODE_NONE = 0;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_OWNED = 1'b1
    } arb_state_e;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    // Index width that never collapses to zero bits.
    function automatic int idx_width(input int n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

endpackage

// File: rtl/bus_rr_arbiter.sv
// Round-robin arbiter: registered one-hot grant with optional hold limit and
// zero-dead-cycle handover when the owner drops its request.
module bus_rr_arbiter
    import bus_pkg::*;
#(
    parameter int N        = 2,
    parameter int HOLD_MAX = 0
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [N-1:0] req_i,
    output logic [N-1:0] grant_o,
    output logic         state_o
);

    localparam int IW = idx_width(N);
    localparam int HW = idx_width(HOLD_MAX);
    // With a hold limit the counter parks at the rotation threshold, otherwise at all-ones.
    localparam logic [HW-1:0] HOLD_SAT = (HOLD_MAX > 0) ? HW'(HOLD_MAX - 1) : {HW{1'b1}};

    arb_state_e    state_q, state_d;
    logic [IW-1:0] owner_q, owner_d;
    logic [IW-1:0] last_q, last_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [N-1:0]  grant_q, grant_d;

    logic          idle_found, next_found;
    logic [IW-1:0] idle_pick, next_pick;

    always_comb begin
        idle_found = 1'b0;
        idle_pick  = '0;
        next_found = 1'b0;
        next_pick  = '0;
        // Descending scans: the last hit is the one closest after the start point.
        for (int j = N; j >= 1; j--) begin
            if (req_i[IW'((int'(last_q) + j) % N)]) begin
                idle_found = 1'b1;
                idle_pick  = IW'((int'(last_q) + j) % N);
            end
        end
        for (int j = N - 1; j >= 1; j--) begin
            if (req_i[IW'((int'(owner_q) + j) % N)]) begin
                next_found = 1'b1;
                next_pick  = IW'((int'(owner_q) + j) % N);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        hold_d  = hold_q;
        unique case (state_q)
            ARB_IDLE: begin
                if (idle_found) begin
                    state_d = ARB_OWNED;
                    owner_d = idle_pick;
                    last_d  = idle_pick;
                    hold_d  = '0;
                end
            end
            ARB_OWNED: begin
                if (req_i[owner_q] && !(HOLD_MAX > 0 && hold_q == HOLD_SAT && next_found)) begin
                    if (hold_q != HOLD_SAT) hold_d = hold_q + HW'(1);
                end else if (next_found) begin
                    owner_d = next_pick;
                    last_d  = next_pick;
                    hold_d  = '0;
                end else begin
                    state_d = ARB_IDLE;
                    hold_d  = '0;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
        grant_d = '0;
        if (state_d == ARB_OWNED) grant_d[owner_d] = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ARB_IDLE;
            owner_q <= '0;
            last_q  <= IW'(N - 1);
            hold_q  <= '0;
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            hold_q  <= hold_d;
            grant_q <= grant_d;
        end
    end

    assign grant_o = grant_q;
    assign state_o = state_q;

endmodule

// File: rtl/bus_matrix_rr.sv
// Shared bus: round-robin master arbitration, upper-address slave decode,
// registered read-return select and unmapped-access flag.
module bus_matrix_rr
    import bus_pkg::*;
#(
    parameter int N_MASTER = 2,
    parameter int N_SLAVE  = 2,
    parameter int AW       = 8,
    parameter int DW       = 8,
    parameter int HOLD_MAX = 0
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [N_MASTER-1:0]    M_req,
    input  logic [N_MASTER*AW-1:0] M_address,
    input  logic [N_MASTER-1:0]    M_wr,
    input  logic [N_MASTER*DW-1:0] M_dout,
    output logic [N_MASTER-1:0]    M_grant,
    output logic [DW-1:0]          M_din,
    output logic [N_SLAVE-1:0]     S_sel,
    output logic [AW-1:0]          S_address,
    output logic                   S_wr,
    output logic [DW-1:0]          S_din,
    input  logic [N_SLAVE*DW-1:0]  S_dout,
    output logic                   dec_err,
    output logic                   arb_state_o
);

    localparam int IDXW = idx_width(N_SLAVE);
    localparam logic [IDXW:0] NS_EXT = (IDXW + 1)'(N_SLAVE);

    logic [N_MASTER-1:0] grant;
    logic [IDXW-1:0]     slave_idx;
    logic                unmapped;
    logic [N_SLAVE-1:0]  rd_sel_q;
    logic                dec_err_q;

    bus_rr_arbiter #(
        .N        (N_MASTER),
        .HOLD_MAX (HOLD_MAX)
    ) u_arb (
        .clk     (clk),
        .reset_n (reset_n),
        .req_i   (M_req),
        .grant_o (grant),
        .state_o (arb_state_o)
    );

    assign M_grant = grant;

    // Grant is one-hot or zero, so AND-OR muxing yields zeros when nobody owns the bus.
    always_comb begin
        S_address = '0;
        S_wr      = 1'b0;
        S_din     = '0;
        for (int i = 0; i < N_MASTER; i++) begin
            S_address = S_address | (M_address[i*AW +: AW] & {AW{grant[i]}});
            S_wr      = S_wr | (M_wr[i] & grant[i]);
            S_din     = S_din | (M_dout[i*DW +: DW] & {DW{grant[i]}});
        end
    end

    assign slave_idx = S_address[AW-1 -: IDXW];
    assign unmapped  = {1'b0, slave_idx} >= NS_EXT;

    always_comb begin
        S_sel = N_SLAVE'(DECODE_NONE);
        if (|grant && !unmapped) S_sel[slave_idx] = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_sel_q  <= '0;
            dec_err_q <= 1'b0;
        end else begin
            rd_sel_q  <= S_sel;
            dec_err_q <= |grant && unmapped;
        end
    end

    always_comb begin
        M_din = '0;
        for (int k = 0; k < N_SLAVE; k++) begin
            M_din = M_din | (S_dout[k*DW +: DW] & {DW{rd_sel_q[k]}});
        end
    end

    assign dec_err = dec_err_q;

endmodule

// File: tb/tb_bus_matrix_rr.sv
// Bench for bus_matrix_rr: default instance (2 slaves, unlimited hold) and a
// 3-slave instance with HOLD_MAX=3, driven from shared master-side inputs.
module tb_bus_matrix_rr;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  M_req, M_wr;
    logic [15:0] M_address, M_dout;
    logic [15:0] S_dout_a;
    logic [23:0] S_dout_b;

    logic [1:0] M_grant_a, S_sel_a;
    logic [7:0] M_din_a, S_address_a, S_din_a;
    logic       S_wr_a, dec_err_a, arb_state_a;

    logic [1:0] M_grant_b;
    logic [2:0] S_sel_b;
    logic [7:0] M_din_b, S_address_b, S_din_b;
    logic       S_wr_b, dec_err_b, arb_state_b;

    int n_checks;
    int n_errors;

    logic [32:0] exp_q[$];
    string       tag_q[$];
    logic [1:0]  prev_sel_a;
    logic [2:0]  prev_sel_b;

    always #5 clk = ~clk;

    bus_matrix_rr dut_a (
        .clk(clk), .reset_n(reset_n), .M_req(M_req), .M_address(M_address),
        .M_wr(M_wr), .M_dout(M_dout), .M_grant(M_grant_a), .M_din(M_din_a),
        .S_sel(S_sel_a), .S_address(S_address_a), .S_wr(S_wr_a), .S_din(S_din_a),
        .S_dout(S_dout_a), .dec_err(dec_err_a), .arb_state_o(arb_state_a)
    );

    bus_matrix_rr #(.N_SLAVE(3), .HOLD_MAX(3)) dut_b (
        .clk(clk), .reset_n(reset_n), .M_req(M_req), .M_address(M_address),
        .M_wr(M_wr), .M_dout(M_dout), .M_grant(M_grant_b), .M_din(M_din_b),
        .S_sel(S_sel_b), .S_address(S_address_b), .S_wr(S_wr_b), .S_din(S_din_b),
        .S_dout(S_dout_b), .dec_err(dec_err_b), .arb_state_o(arb_state_b)
    );

    // Packed observation: {owned, grant, sel[2:0], wr, dec_err, address, s_din, m_din}
    function automatic logic [31:0] obs_a();
        return {arb_state_a, M_grant_a, 1'b0, S_sel_a, S_wr_a, dec_err_a, S_address_a, S_din_a, M_din_a};
    endfunction

    function automatic logic [31:0] obs_b();
        return {arb_state_b, M_grant_b, S_sel_b, S_wr_b, dec_err_b, S_address_b, S_din_b, M_din_b};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Push what the given instance must show after the next edge (inst 0 = a, 1 = b).
    task automatic expect_x(input bit inst, input string tag, input logic [1:0] g,
                            input logic [2:0] sel, input logic derr);
        logic [7:0] addr, sdin, din;
        logic       wr;
        addr = '0; sdin = '0; wr = 1'b0; din = '0;
        if (g[0]) begin
            addr = M_address[7:0];  sdin = M_dout[7:0];  wr = M_wr[0];
        end else if (g[1]) begin
            addr = M_address[15:8]; sdin = M_dout[15:8]; wr = M_wr[1];
        end
        if (inst == 1'b0) begin
            if (prev_sel_a[0]) din = S_dout_a[7:0];
            if (prev_sel_a[1]) din = S_dout_a[15:8];
            prev_sel_a = sel[1:0];
        end else begin
            if (prev_sel_b[0]) din = S_dout_b[7:0];
            if (prev_sel_b[1]) din = S_dout_b[15:8];
            if (prev_sel_b[2]) din = S_dout_b[23:16];
            prev_sel_b = sel;
        end
        exp_q.push_back({inst, |g, g, sel, wr, derr, addr, sdin, din});
        tag_q.push_back(tag);
    endtask

    task automatic compare_now();
        logic [32:0] e;
        string       t;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            if (e[32]) check(t, obs_b(), e[31:0]);
            else       check(t, obs_a(), e[31:0]);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        compare_now();
    endtask

    task automatic do_reset(input string tag);
        reset_n = 1'b0;
        M_req   = 2'b00;
        #1;
        prev_sel_a = '0;
        prev_sel_b = '0;
        expect_x(1'b0, {tag, "_a"}, 2'b00, 3'b000, 1'b0);
        expect_x(1'b1, {tag, "_b"}, 2'b00, 3'b000, 1'b0);
        compare_now();
        @(posedge clk);
        #1;
        expect_x(1'b0, {tag, "_held_a"}, 2'b00, 3'b000, 1'b0);
        expect_x(1'b1, {tag, "_held_b"}, 2'b00, 3'b000, 1'b0);
        compare_now();
        reset_n = 1'b1;
    endtask

    logic [1:0] t2_req[5]   = '{2'b11, 2'b10, 2'b01, 2'b10, 2'b00};
    logic [1:0] t2_grant[5] = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b00};
    logic [1:0] t3_grant[7] = '{2'b01, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b01};

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        prev_sel_a = '0;
        prev_sel_b = '0;
        reset_n    = 1'b0;
        M_req      = '0;
        M_wr       = '0;
        M_address  = '0;
        M_dout     = 16'($urandom_range(0, 65535));
        S_dout_a   = 16'($urandom_range(0, 65535));
        S_dout_b   = 24'($urandom_range(0, 24'hFFFFFF));

        do_reset("rst");

        // Single write from M0 to the upper slave
        M_address[7:0] = 8'h85;
        M_wr           = 2'b01;
        M_req          = 2'b01;
        expect_x(1'b0, "t1_grant", 2'b01, 3'b010, 1'b0); tick();
        expect_x(1'b0, "t1_hold", 2'b01, 3'b010, 1'b0); tick();
        M_req = 2'b00;
        expect_x(1'b0, "t1_release", 2'b00, 3'b000, 1'b0); tick();
        expect_x(1'b0, "t1_idle", 2'b00, 3'b000, 1'b0); tick();

        do_reset("rst2");

        // Alternating ownership with immediate handover
        M_address = {8'h85, 8'h05};
        M_wr      = 2'b00;
        M_dout    = 16'($urandom_range(0, 65535));
        for (int i = 0; i < 5; i++) begin
            M_req = t2_req[i];
            expect_x(1'b0, "t2_alt", t2_grant[i], {1'b0, t2_grant[i]}, 1'b0);
            tick();
        end
        expect_x(1'b0, "t2_idle", 2'b00, 3'b000, 1'b0); tick();

        // Read from slave 0 by M1
        M_address[15:8] = 8'h10;
        S_dout_a        = {8'($urandom_range(0, 255)), 8'hA5};
        M_req           = 2'b10;
        expect_x(1'b0, "t4_grant", 2'b10, 3'b001, 1'b0); tick();
        M_req = 2'b00;
        expect_x(1'b0, "t4_data", 2'b00, 3'b000, 1'b0); tick();
        check("t4_din_a5", {24'h0, M_din_a}, 32'h0000_00A5);
        expect_x(1'b0, "t4_drop", 2'b00, 3'b000, 1'b0); tick();

        // Reset asserted while M0 owns the bus
        M_address = {8'h85, 8'h05};
        M_req     = 2'b11;
        expect_x(1'b0, "t6_grant", 2'b01, 3'b001, 1'b0); tick();
        reset_n = 1'b0;
        #1;
        prev_sel_a = '0;
        prev_sel_b = '0;
        expect_x(1'b0, "t6_async_a", 2'b00, 3'b000, 1'b0);
        expect_x(1'b1, "t6_async_b", 2'b00, 3'b000, 1'b0);
        compare_now();
        @(posedge clk);
        #1;
        expect_x(1'b0, "t6_held", 2'b00, 3'b000, 1'b0);
        compare_now();
        reset_n = 1'b1;
        expect_x(1'b0, "t6_restart", 2'b01, 3'b001, 1'b0); tick();
        M_req = 2'b00;
        expect_x(1'b0, "t6_idle", 2'b00, 3'b000, 1'b0); tick();
        expect_x(1'b0, "t6_idle2", 2'b00, 3'b000, 1'b0); tick();

        do_reset("rst3");

        // Hold limit of 3 on the 3-slave instance
        M_address = {8'h45, 8'h05};
        M_wr      = 2'b00;
        M_dout    = 16'($urandom_range(0, 65535));
        S_dout_b  = 24'($urandom_range(0, 24'hFFFFFF));
        M_req     = 2'b11;
        for (int i = 0; i < 7; i++) begin
            expect_x(1'b1, "t3_hold", t3_grant[i], (t3_grant[i] == 2'b01) ? 3'b001 : 3'b010, 1'b0);
            tick();
        end
        M_req = 2'b00;
        expect_x(1'b1, "t3_idle", 2'b00, 3'b000, 1'b0); tick();

        // Unmapped slave index 3 on the 3-slave instance
        M_address[7:0] = 8'hC0;
        M_req          = 2'b01;
        expect_x(1'b1, "t5_grant", 2'b01, 3'b000, 1'b0); tick();
        M_req = 2'b00;
        expect_x(1'b1, "t5_err", 2'b00, 3'b000, 1'b1); tick();
        expect_x(1'b1, "t5_clear", 2'b00, 3'b000, 1'b0); tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
